// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: shares one single-port RAM between the display fetch and the Sobel writer,
// generates linear read addresses, pipelines pixels to the DAC and tracks frame/stall statistics.
module frame_buffer_arbiter #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              active_video_i,
    input  logic              v_sync_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ack_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] pix_out_o,
    output logic              pix_valid_o,
    output logic              frame_start_o,
    output logic              frame_err_o,
    output logic [15:0]       wr_stall_cnt_o
);

    // state   | meaning
    // WAIT_VS | no frame seen yet; reads idle, writer owns the RAM
    // RUN     | display fetch owns the RAM during active video
    typedef enum logic {WAIT_VS = 1'b0, RUN = 1'b1} state_t;

    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W:0]   NPIX_CNT  = (ADDR_W + 1)'(NPIX);

    state_t              state_q, state_d;
    logic                vs_q;
    logic                fall;
    logic                rd_claim;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]     pix_cnt_q, pix_cnt_d;
    logic                frame_err_q, frame_err_d;
    logic [15:0]         stall_q, stall_d;
    logic                rd_v1_q;
    logic                pix_valid_q;
    logic [DATA_W-1:0]   pix_out_q, pix_out_d;
    logic                frame_start_q;
    logic                wr_ack;

    assign fall     = vs_q & ~v_sync_i;
    assign rd_claim = (state_q == RUN) & active_video_i;
    assign wr_ack   = wr_req_i & ~rd_claim & ~reset_i;

    assign wr_ack_o       = wr_ack;
    assign mem_we_o       = wr_ack;
    assign mem_wdata_o    = wr_data_i;
    assign mem_addr_o     = rd_claim ? rd_addr_q : wr_addr_i;
    assign pix_out_o      = pix_out_q;
    assign pix_valid_o    = pix_valid_q;
    assign frame_start_o  = frame_start_q;
    assign frame_err_o    = frame_err_q;
    assign wr_stall_cnt_o = stall_q;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        pix_cnt_d   = pix_cnt_q;
        frame_err_d = frame_err_q;
        stall_d     = stall_q;
        pix_out_d   = rd_v1_q ? mem_rdata_i : pix_out_q;

        if (state_q == WAIT_VS && fall) begin
            state_d = RUN;
        end

        // The edge check sees the count of the finished frame before it is cleared.
        if (fall) begin
            if (state_q == RUN && pix_cnt_q != NPIX_CNT) begin
                frame_err_d = 1'b1;
            end
            rd_addr_d = '0;
            pix_cnt_d = '0;
            stall_d   = '0;
        end else begin
            if (rd_claim) begin
                rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
                if (!(&pix_cnt_q)) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            if (wr_req_i && !wr_ack && !(&stall_q)) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= WAIT_VS;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
            rd_addr_q     <= '0;
            pix_cnt_q     <= '0;
            frame_err_q   <= 1'b0;
            stall_q       <= '0;
            rd_v1_q       <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            vs_q          <= v_sync_i;
            frame_start_q <= fall;
            rd_addr_q     <= rd_addr_d;
            pix_cnt_q     <= pix_cnt_d;
            frame_err_q   <= frame_err_d;
            stall_q       <= stall_d;
            rd_v1_q       <= rd_claim;
            pix_valid_q   <= rd_v1_q;
            pix_out_q     <= pix_out_d;
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Testbench for frame_buffer_arbiter: random writer traffic over structured video frames,
// compared every cycle against a frame-level reference model.
module tb_frame_buffer_arbiter;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int CNT_MAX = (1 << (ADDR_W + 1)) - 1;

    logic              clk = 1'b0;
    logic              reset, active_video, v_sync, wr_req;
    logic [ADDR_W-1:0] wr_addr, mem_addr;
    logic [DATA_W-1:0] wr_data, mem_wdata, mem_rdata, pix_out;
    logic              wr_ack, mem_we, pix_valid, frame_start, frame_err;
    logic [15:0]       wr_stall_cnt;

    int checks = 0;
    int errors = 0;

    // reference model
    bit m_run, m_vs, m_err, m_fs, last_ack;
    int m_rd, m_cnt, m_stall, exp_pix;
    int pq[$];

    always #5 clk = ~clk;

    // RAM returns the low byte of the address one cycle later
    always @(posedge clk) mem_rdata <= mem_addr[DATA_W-1:0];

    frame_buffer_arbiter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .reset_i(reset), .active_video_i(active_video), .v_sync_i(v_sync),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .pix_out_o(pix_out), .pix_valid_o(pix_valid), .frame_start_o(frame_start),
        .frame_err_o(frame_err), .wr_stall_cnt_o(wr_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_vs = 1; m_err = 0; m_fs = 0;
        m_rd = 0; m_cnt = 0; m_stall = 0;
        pq = {-1};
        exp_pix = -1;
    endtask

    // One clock: check grant/mux before the edge, advance the model, check registered outputs after it.
    task automatic cyc();
        bit fall, claim, ack;
        #1;
        fall  = m_vs & ~v_sync;
        claim = m_run & active_video;
        ack   = wr_req & ~claim & ~reset;
        chk("wr_ack", 32'(wr_ack), 32'(ack));
        chk("mem_we", 32'(mem_we), 32'(ack));
        chk("mem_addr", 32'(mem_addr), claim ? 32'(m_rd) : 32'(wr_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(wr_data));
        last_ack = ack;
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            pq.push_back(claim ? (m_rd % 256) : -1);
            exp_pix = pq.pop_front();
            m_fs = fall;
            m_vs = v_sync;
            if (fall) begin
                if (m_run && m_cnt != NPIX) m_err = 1;
                m_run = 1; m_rd = 0; m_cnt = 0; m_stall = 0;
            end else begin
                if (claim) begin
                    m_rd = (m_rd + 1) % NPIX;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
                if (wr_req && !ack && m_stall < 65535) m_stall++;
            end
        end
        chk("pix_valid", 32'(pix_valid), 32'(exp_pix >= 0));
        if (exp_pix >= 0) chk("pix_out", 32'(pix_out), 32'(exp_pix));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("wr_stall_cnt", 32'(wr_stall_cnt), 32'(m_stall));
    endtask

    // Writer holds a request until it is granted, then may pick a new one.
    task automatic next_wr();
        if (!wr_req || last_ack) begin
            wr_req  = 1'($urandom_range(0, 1));
            wr_addr = ADDR_W'($urandom);
            wr_data = DATA_W'($urandom);
        end
    endtask

    task automatic run_frame(input int npix, input bit hold_line0);
        active_video = 0;
        v_sync = 0;
        repeat (2) begin next_wr(); cyc(); end
        v_sync = 1;
        repeat ($urandom_range(1, 3)) begin next_wr(); cyc(); end
        if (hold_line0) begin
            wr_req = 1; wr_addr = 12'h123; wr_data = 8'h3C;
        end
        for (int p = 0; p < npix; p++) begin
            active_video = 1;
            if (!(hold_line0 && p < IMG_W)) next_wr();
            cyc();
            if (hold_line0 && p == IMG_W - 1) chk("stall_line", 32'(wr_stall_cnt), 32'd64);
            if (p % IMG_W == IMG_W - 1) begin
                active_video = 0;
                if (hold_line0 && p == IMG_W - 1) cyc();
                repeat ($urandom_range(1, 3)) begin next_wr(); cyc(); end
            end
        end
        active_video = 0;
        repeat (2) begin next_wr(); cyc(); end
    endtask

    initial begin
        reset = 1; active_video = 0; v_sync = 1;
        wr_req = 1; wr_addr = 12'd7; wr_data = 8'h11;
        last_ack = 0;
        model_reset();
        @(posedge clk);
        #1;
        cyc();
        chk("rst_pix_out", 32'(pix_out), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);

        reset = 0; wr_req = 1; wr_addr = 12'd5; wr_data = 8'hA5;
        cyc();
        chk("wait_frame_start", 32'(frame_start), 32'd0);
        for (int i = 0; i < 6; i++) begin
            active_video = 1'($urandom_range(0, 1));
            next_wr();
            cyc();
        end

        run_frame(NPIX, 1);
        run_frame(NPIX - 1, 0);
        run_frame(NPIX, 0);
        chk("err_set", 32'(frame_err), 32'd1);

        // next fall checks a correct frame; error must stay set, then reset mid-line
        v_sync = 0; active_video = 0;
        repeat (2) begin next_wr(); cyc(); end
        chk("err_sticky", 32'(frame_err), 32'd1);
        v_sync = 1; cyc();
        active_video = 1; wr_req = 1;
        repeat (20) cyc();
        reset = 1;
        cyc();
        chk("midrst_valid", 32'(pix_valid), 32'd0);
        chk("midrst_stall", 32'(wr_stall_cnt), 32'd0);
        chk("midrst_err", 32'(frame_err), 32'd0);
        reset = 0;
        repeat (30) begin next_wr(); cyc(); end

        // enter RUN, then keep the writer stalled long enough to saturate
        active_video = 0; v_sync = 0;
        repeat (2) begin next_wr(); cyc(); end
        v_sync = 1; cyc();
        active_video = 1; wr_req = 1; wr_addr = 12'h0AB; wr_data = 8'h5A;
        repeat (65600) cyc();
        chk("stall_sat", 32'(wr_stall_cnt), 32'h0000FFFF);
        active_video = 0; v_sync = 0;
        cyc();
        chk("stall_clear", 32'(wr_stall_cnt), 32'd0);
        chk("err_oversize", 32'(frame_err), 32'd1);
        v_sync = 1;
        repeat (3) begin next_wr(); cyc(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Shares the single-port frame buffer RAM between two requesters: the VGA display fetch, paced by the sync generator's `active_video`/`v_sync`, and the Sobel result writer. Display reads have absolute priority inside the active window. Writes are granted in every other cycle. The block also generates linear read addresses, pipelines pixels to the DAC stage, and reports frame-length errors and write stalls.

## Interface
- `IMG_W`, default 64: active window width in pixels.
- `IMG_H`, default 64: active window height in lines.
- `ADDR_W`, default 12: RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- `DATA_W`, default 8: pixel width.
- `clk`  in  1  pixel clock; one clock only.
- `reset`  in  1  synchronous, active-high.
- `active_video`  in  1  high for each displayed pixel.
- `v_sync`  in  1  active-low vertical sync.
- `wr_req`  in  1  writer request. Must hold stable with `wr_addr`/`wr_data` until `wr_ack`.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `wr_ack`  out  1  combinational grant; the write commits at this clock edge.
- `mem_addr`  out  ADDR_W  RAM address (combinational mux).
- `mem_we`  out  1  RAM write enable, equal to `wr_ack`.
- `mem_wdata`  out  DATA_W  equal to `wr_data`.
- `mem_rdata`  in  DATA_W  RAM read data, registered inside the RAM (1-cycle latency).
- `pix_out`  out  DATA_W  registered pixel to the display.
- `pix_valid`  out  1  qualifies `pix_out`.
- `frame_start`  out  1  one-cycle pulse on each `v_sync` falling edge.
- `frame_err`  out  1  sticky; a frame had a pixel count other than IMG_W*IMG_H.
- `wr_stall_cnt`  out  16  number of cycles with `wr_req` high and `wr_ack` low in the current frame.

## Operation
- Falling-edge detection:
  - `vs_d` registers `v_sync`; it resets to 1.
  - A falling edge is `vs_d & ~v_sync`.
  - `frame_start` is the registered form of this condition: high in the cycle after the edge is sampled.
- State machine with two states, WAIT_VS and RUN:
  - Reset enters WAIT_VS.
  - WAIT_VS -> RUN on the first falling edge.
  - RUN is held until reset.
  - In WAIT_VS no reads are issued, `pix_valid` stays 0 and every `wr_req` is granted.
- Read claim: `rd_claim = (state==RUN) & active_video`.
- Arbitration:
  - `wr_ack = wr_req & ~rd_claim & ~reset`.
  - `mem_addr = rd_claim ? rd_addr : wr_addr`.
- Read address `rd_addr`:
  - Increments on each `rd_claim` cycle.
  - Wraps from IMG_W*IMG_H-1 to 0.
  - Is forced to 0 on a falling edge. This takes priority over the increment; a read issued in that same cycle uses the old address.
- Pixel counter `pix_cnt`:
  - ADDR_W+1 bits, saturating.
  - Counts `rd_claim` cycles.
  - Cleared on each falling edge after being checked.
- Frame check on each falling edge while in RUN:
  - If `pix_cnt != IMG_W*IMG_H`, set `frame_err`.
  - The WAIT_VS -> RUN edge is not checked.
  - `frame_err` clears only on reset.
- Stall counter `wr_stall_cnt`:
  - Increments when `wr_req & ~wr_ack`.
  - Saturates at 16'hFFFF.
  - Cleared on a falling edge. The clear wins over a same-cycle increment.

## Timing
- Reset values: `pix_out`=0, `pix_valid`=0, `frame_start`=0, `frame_err`=0, `wr_stall_cnt`=0, `rd_addr`=0, `pix_cnt`=0, state=WAIT_VS.
- `wr_ack`/`mem_we` are 0 while `reset` is high.
- Read latency is 2 cycles:
  - `rd_claim` in cycle n drives `mem_addr` in cycle n.
  - `mem_rdata` is valid in cycle n+1.
  - `pix_out`/`pix_valid` are registered at the end of n+1 and visible in n+2.
  - `pix_valid` is `rd_claim` delayed by 2 flops.
  - The top level delays `h_sync`/`v_sync` by 2 cycles to match.
- Write latency: zero-wait when granted. Worst-case stall equals the active-window run length (IMG_W cycles per line).
- Reset asserted mid-frame: all registers return to reset values on the next edge. Any in-flight pixels are discarded, so `pix_valid`=0 from the first cycle after reset.
- `wr_req` simultaneous with `rd_claim`: the read wins, `wr_ack`=0, and the stall counter increments.

## Test plan
- Reset, then `wr_req`=1 with `wr_addr`=5 and `wr_data`=8'hA5 while `v_sync`=1 -> `wr_ack`=1 the same cycle, `mem_we`=1, `mem_addr`=5, `frame_start` stays 0.
- Falling edge on `v_sync`, then 4096 `active_video` cycles with the RAM model returning data equal to the address -> `frame_start` pulses once. `pix_out` sequence is 0,1,…,255 (low 8 bits), with `pix_valid` exactly 2 cycles after each `active_video`. `rd_addr` wraps to 0.
- `wr_req` held high across a 64-cycle active line -> `wr_ack`=0 for 64 cycles and `wr_stall_cnt`=64, then `wr_ack`=1 in the first blanking cycle.
- Second frame with only 4095 active cycles before the next `v_sync` fall -> `frame_err`=1 after that edge and it stays 1. A following correct frame does not clear it.
- Reset asserted for 1 cycle mid-line -> `pix_valid`=0, `wr_stall_cnt`=0, state WAIT_VS; `active_video` is ignored until the next `v_sync` fall.
- `wr_stall_cnt` driven past 65535 -> holds at 16'hFFFF, then returns to 0 on the next falling edge.
